// File: rtl/spi_avalon_master.sv
// spi_avalon_master
// Turns one Avalon-style command (single 32-bit read or write) into a
// mode-0 SPI frame. The frame is an 8-bit header {write, 3'b000, byte_enable},
// then the 32-bit address, then a 32-bit data phase, all MSB first.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_write            1 = write, 0 = read
//   cmd_address          32-bit address
//   cmd_write_data       32-bit write payload
//   cmd_byte_enable      4 byte lanes
//   rsp_valid            one-cycle completion pulse
//   rsp_read_data        read word (0 after a write), held until next rsp_valid
//   busy                 high whenever the FSM is not in IDLE
//   spi_clk, csn, mosi   SPI master outputs
//   miso                 SPI master input (asynchronous, synchronized here)
//
// State table
//   state      | meaning
//   IDLE       | waiting for a command, cmd_ready high
//   CS_SETUP   | csn low, spi_clk low, first frame bit already on mosi
//   SHIFT_HDR  | 40 bit periods: header + address
//   TURN       | read turnaround, spi_clk low, mosi 0
//   SHIFT_DATA | 32 bit periods: write data out / read data in
//   CS_HOLD    | csn still low, spi_clk low
//   CS_HIGH    | csn high, rsp_valid in its first cycle
module spi_avalon_master #(
    parameter int CLK_DIV     = 4,
    parameter int TURN_CYCLES = 16,
    parameter int CS_GAP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_write_data,
    input  logic [3:0]  cmd_byte_enable,
    output logic        rsp_valid,
    output logic [31:0] rsp_read_data,
    output logic        busy,
    output logic        spi_clk,
    output logic        csn,
    output logic        mosi,
    input  logic        miso
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int TURN_W = $clog2(TURN_CYCLES + 1);
    localparam int GAP_W  = $clog2(CS_GAP + 1);

    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(CS_GAP - 1);
    // CS_HIGH plus the following IDLE (acceptance) cycle together give the
    // CS_GAP cycles of csn high, so CS_HIGH itself lasts CS_GAP-1 cycles
    // (never less than the single rsp_valid cycle).
    localparam logic [GAP_W-1:0]  HIGH_LOAD = GAP_W'((CS_GAP > 1) ? CS_GAP - 2 : 0);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT_HDR,
        TURN,
        SHIFT_DATA,
        CS_HOLD,
        CS_HIGH
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [71:0]        r_shift;
    logic               r_write;
    logic [6:0]         r_bits;
    logic [DIV_W-1:0]   r_div;
    logic               r_phase;
    logic [TURN_W-1:0]  r_turn;
    logic [GAP_W-1:0]   r_gap;
    logic               r_miso_meta;
    logic               r_miso_sync;
    logic [31:0]        r_rd_shift;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_read_data;

    logic               w_shifting;
    logic               w_bit_end;
    logic               w_last_bit;

    assign w_shifting = (r_state == SHIFT_HDR) || (r_state == SHIFT_DATA);
    // r_phase: 0 = low half of the bit period, 1 = high half
    assign w_bit_end  = (r_div == '0) && r_phase;
    assign w_last_bit = w_bit_end && (r_bits == 7'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:       if (cmd_valid)       w_state_next = CS_SETUP;
            CS_SETUP:   if (r_gap == '0)     w_state_next = SHIFT_HDR;
            SHIFT_HDR:  if (w_last_bit)      w_state_next = r_write ? SHIFT_DATA : TURN;
            TURN:       if (r_turn == '0)    w_state_next = SHIFT_DATA;
            SHIFT_DATA: if (w_last_bit)      w_state_next = CS_HOLD;
            CS_HOLD:    if (r_gap == '0)     w_state_next = CS_HIGH;
            CS_HIGH:    if (r_gap == '0)     w_state_next = IDLE;
            default:                         w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift         <= '0;
            r_write         <= 1'b0;
            r_bits          <= '0;
            r_div           <= '0;
            r_phase         <= 1'b0;
            r_turn          <= '0;
            r_gap           <= '0;
            r_miso_meta     <= 1'b0;
            r_miso_sync     <= 1'b0;
            r_rd_shift      <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_read_data <= '0;
        end else begin
            r_miso_meta <= miso;
            r_miso_sync <= r_miso_meta;
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_write    <= cmd_write;
                        // read frames carry zeros in the data phase
                        r_shift    <= {cmd_write, 3'b000, cmd_byte_enable, cmd_address,
                                       cmd_write ? cmd_write_data : 32'd0};
                        r_gap      <= GAP_LOAD;
                        r_rd_shift <= '0;
                    end
                end
                CS_SETUP: begin
                    if (r_gap == '0) begin
                        r_bits  <= 7'd39;
                        r_div   <= DIV_LOAD;
                        r_phase <= 1'b0;
                    end else begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                SHIFT_HDR, SHIFT_DATA: begin
                    if (r_div != '0) begin
                        r_div <= r_div - DIV_W'(1);
                    end else begin
                        r_div   <= DIV_LOAD;
                        r_phase <= !r_phase;
                        // spi_clk rises on this edge: capture miso
                        if (!r_phase && (r_state == SHIFT_DATA)) begin
                            r_rd_shift <= {r_rd_shift[30:0], r_miso_sync};
                        end
                        // end of bit period: next bit onto mosi while spi_clk goes low
                        if (r_phase) begin
                            r_shift <= {r_shift[70:0], 1'b0};
                            if (r_bits != 7'd0) begin
                                r_bits <= r_bits - 7'd1;
                            end else if (r_state == SHIFT_HDR) begin
                                r_bits <= 7'd31;
                                r_turn <= TURN_LOAD;
                            end else begin
                                r_gap <= GAP_LOAD;
                            end
                        end
                    end
                end
                TURN: begin
                    if (r_turn != '0) begin
                        r_turn <= r_turn - TURN_W'(1);
                    end
                end
                CS_HOLD: begin
                    if (r_gap == '0) begin
                        r_rsp_valid     <= 1'b1;
                        r_rsp_read_data <= r_write ? 32'd0 : r_rd_shift;
                        r_gap           <= HIGH_LOAD;
                    end else begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                CS_HIGH: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready     = (r_state == IDLE) && !rst;
    assign busy          = (r_state != IDLE);
    assign csn           = (r_state == IDLE) || (r_state == CS_HIGH);
    assign spi_clk       = w_shifting && r_phase;
    assign mosi          = ((r_state == CS_SETUP) || w_shifting) ? r_shift[71] : 1'b0;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_read_data = r_rsp_read_data;

endmodule
